// File: rtl/switch_allocator.sv
// rtl/switch_allocator.sv - per-output round-robin wormhole allocator driving crossbar buffer grants
// Optional idle-ack forced release enabled by defining SW_ALLOC_TIMEOUT_EN.
module switch_allocator #(
  parameter int unsigned SINGLE_FLIT    = 0,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TO_WIDTH       = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [4:0]      buf_valid,
  input  logic [4:0]      buf_tail,
  input  logic [0:4][2:0] dests,
  input  logic [4:0]      buf_ack,
  output logic [4:0]      buffer_grants,
  output logic [4:0]      out_busy,
  output logic [0:4][2:0] out_owner,
  output logic [4:0]      bad_dest
`ifdef SW_ALLOC_TIMEOUT_EN
  ,
  output logic [4:0]      timeout
`endif
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t          state_q [5];
  logic [0:4][2:0] ptr_q;
  logic [4:0]      cand [5];
  logic [3:0]      win [5];
  logic [4:0]      rel;
  logic [4:0]      force_rel;
  logic [4:0]      bad_now;

  if (TIMEOUT_CYCLES >= (2 ** TO_WIDTH)) begin : g_bad_cfg
    $error("TIMEOUT_CYCLES does not fit in TO_WIDTH bits");
  end

  // Search order starts just after the last owner, wrapping at buffer 4.
  function automatic logic [3:0] pick(input logic [2:0] ptr, input logic [4:0] req);
    logic [2:0] idx;
    logic [3:0] r;
    r   = '0;
    idx = ptr;
    for (int k = 0; k < 5; k++) begin
      idx = (idx == 3'd4) ? 3'd0 : idx + 3'd1;
      if (!r[3] && req[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

  always_comb begin
    buffer_grants = '0;
    out_busy      = '0;
    for (int o = 0; o < 5; o++) begin
      if (state_q[o] == LOCKED) begin
        buffer_grants[out_owner[o]] = 1'b1;
        out_busy[o]                 = 1'b1;
      end
    end
  end

  always_comb begin
    rel     = '0;
    bad_now = '0;
    for (int i = 0; i < 5; i++) bad_now[i] = buf_valid[i] && (dests[i] > 3'd4);
    for (int o = 0; o < 5; o++) begin
      cand[o] = '0;
      for (int i = 0; i < 5; i++)
        cand[o][i] = buf_valid[i] && (dests[i] == 3'(o)) && !buffer_grants[i];
      win[o] = pick(ptr_q[o], cand[o]);
      rel[o] = (state_q[o] == LOCKED) && buf_ack[out_owner[o]] &&
               (buf_tail[out_owner[o]] || (SINGLE_FLIT != 0));
    end
  end

`ifdef SW_ALLOC_TIMEOUT_EN
  localparam logic [TO_WIDTH-1:0] TO_LIMIT = TO_WIDTH'(TIMEOUT_CYCLES);
  logic [0:4][TO_WIDTH-1:0] to_cnt_q;

  always_comb begin
    force_rel = '0;
    for (int o = 0; o < 5; o++)
      force_rel[o] = (state_q[o] == LOCKED) && (to_cnt_q[o] == TO_LIMIT);
  end

  assign timeout = force_rel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q <= '0;
    end else begin
      for (int o = 0; o < 5; o++) begin
        if (state_q[o] == IDLE || buf_ack[out_owner[o]]) to_cnt_q[o] <= '0;
        else                                             to_cnt_q[o] <= to_cnt_q[o] + 1'b1;
      end
    end
  end
`else
  assign force_rel = '0;
`endif

  // The release cycle never re-arbitrates, leaving a one-cycle gap per output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int o = 0; o < 5; o++) state_q[o] <= IDLE;
      ptr_q     <= {5{3'd4}};
      out_owner <= '0;
      bad_dest  <= '0;
    end else begin
      bad_dest <= bad_now;
      for (int o = 0; o < 5; o++) begin
        case (state_q[o])
          IDLE: begin
            if (win[o][3]) begin
              state_q[o]   <= LOCKED;
              out_owner[o] <= win[o][2:0];
            end
          end
          LOCKED: begin
            if (rel[o] || force_rel[o]) begin
              state_q[o] <= IDLE;
              ptr_q[o]   <= out_owner[o];
            end
          end
          default: state_q[o] <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_switch_allocator.sv
// tb/tb_switch_allocator.sv - scoreboard bench for switch_allocator against a behavioural model
module tb_switch_allocator;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [4:0]      buf_valid, buf_tail, buf_ack;
  logic [0:4][2:0] dests;
  logic [4:0]      buffer_grants, out_busy, bad_dest;
  logic [0:4][2:0] out_owner;
`ifdef SW_ALLOC_TIMEOUT_EN
  logic [4:0]      timeout;
`endif

  always #5 clk = ~clk;

  switch_allocator dut (
    .clk(clk), .rst_n(rst_n), .buf_valid(buf_valid), .buf_tail(buf_tail),
    .dests(dests), .buf_ack(buf_ack), .buffer_grants(buffer_grants),
    .out_busy(out_busy), .out_owner(out_owner), .bad_dest(bad_dest)
`ifdef SW_ALLOC_TIMEOUT_EN
    , .timeout(timeout)
`endif
  );

  typedef struct {
    logic [4:0]      g;
    logic [4:0]      b;
    logic [4:0]      bad;
    logic [0:4][2:0] own;
  } exp_t;

  exp_t sbq[$];
  int   nvec = 0;
  int   nerr = 0;
  int   m_own[5];
  int   m_ptr[5];
  logic [4:0] m_bad;

  task automatic chk(input string name, input int act, input int req);
    nvec++;
    if (act != req) begin
      nerr++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic model_reset();
    for (int o = 0; o < 5; o++) begin
      m_own[o] = -1;
      m_ptr[o] = 4;
    end
    m_bad = '0;
  endtask

  // Owner -1 means the output is free; free outputs pick the next requester after ptr.
  task automatic model_step();
    int nown[5];
    bit taken[5];
    bit found;
    int i;
    for (int k = 0; k < 5; k++) taken[k] = 0;
    for (int o = 0; o < 5; o++) if (m_own[o] >= 0) taken[m_own[o]] = 1;
    for (int o = 0; o < 5; o++) begin
      nown[o] = m_own[o];
      if (m_own[o] >= 0) begin
        if (buf_ack[m_own[o]] && buf_tail[m_own[o]]) begin
          m_ptr[o] = m_own[o];
          nown[o]  = -1;
        end
      end else begin
        found = 0;
        for (int k = 1; k <= 5; k++) begin
          i = (m_ptr[o] + k) % 5;
          if (!found && buf_valid[i] && int'(dests[i]) == o && !taken[i]) begin
            found   = 1;
            nown[o] = i;
          end
        end
      end
    end
    for (int o = 0; o < 5; o++) m_own[o] = nown[o];
    for (int k = 0; k < 5; k++) m_bad[k] = buf_valid[k] && (int'(dests[k]) > 4);
  endtask

  task automatic push_exp();
    exp_t e;
    e.g = '0; e.b = '0; e.own = '0; e.bad = m_bad;
    for (int o = 0; o < 5; o++) begin
      if (m_own[o] >= 0) begin
        e.g[m_own[o]] = 1'b1;
        e.b[o]        = 1'b1;
        e.own[o]      = 3'(m_own[o]);
      end
    end
    sbq.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        if (rst_n) begin
          chk("grants", int'(buffer_grants), int'(e.g));
          chk("busy", int'(out_busy), int'(e.b));
          chk("bad_dest", int'(bad_dest), int'(e.bad));
          for (int o = 0; o < 5; o++) begin
            if (e.b[o]) chk($sformatf("owner%0d", o), int'(out_owner[o]), int'(e.own[o]));
            for (int p = o + 1; p < 5; p++)
              if (out_busy[o] && out_busy[p])
                chk("dup_owner", int'(out_owner[o] == out_owner[p]), 0);
          end
        end
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    if (rst_n) begin
      model_step();
      push_exp();
    end
    #1;
  endtask

  task automatic drive(input logic [4:0] v, input logic [4:0] t, input logic [4:0] a,
                       input logic [0:4][2:0] d);
    buf_valid = v; buf_tail = t; buf_ack = a; dests = d;
  endtask

  task automatic do_reset();
    drive(5'b0, 5'b0, 5'b0, '0);
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    chk("reset_busy", int'(out_busy), 0);
    rst_n = 1'b1;
  endtask

  initial begin : stim
    logic [4:0] fcnt, g_before;
    int exp2[9];
    int expown[9];
    exp2   = '{2, 2, 0, 8, 8, 0, 2, 2, 0};
    expown = '{1, -1, -1, 3, -1, -1, 1, -1, -1};
    model_reset();

    drive(5'b11111, 5'b0, 5'b0, {3'd0, 3'd1, 3'd2, 3'd3, 3'd4});
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk("rst_grants", int'(buffer_grants), 0);
      chk("rst_busy", int'(out_busy), 0);
      chk("rst_owner", int'(out_owner), 0);
      chk("rst_bad", int'(bad_dest), 0);
    end
    rst_n = 1'b1;
    cycle();
    chk("first_grant", int'(buffer_grants), 31);

    do_reset();
    fcnt = '0;
    for (int c = 0; c < 9; c++) begin
      drive(5'b01010, fcnt & 5'b01010, 5'b11111, {5{3'd2}});
      g_before = buffer_grants;
      cycle();
      fcnt = fcnt ^ g_before;
      chk($sformatf("rr_grant_c%0d", c), int'(buffer_grants), exp2[c]);
      if (expown[c] >= 0) chk($sformatf("rr_owner_c%0d", c), int'(out_owner[2]), expown[c]);
    end

    do_reset();
    drive(5'b10001, 5'b0, 5'b0, {3'd3, 3'd0, 3'd0, 3'd0, 3'd0});
    cycle();
    chk("par_grants", int'(buffer_grants), 17);
    chk("par_busy", int'(out_busy), 9);

    do_reset();
    drive(5'b00100, 5'b0, 5'b0, {3'd0, 3'd0, 3'd1, 3'd0, 3'd0});
    cycle();
    for (int c = 0; c < 10; c++) begin
      drive(5'b0, 5'b0, 5'b0, {3'd0, 3'd0, 3'd1, 3'd0, 3'd0});
      cycle();
      chk("hold_grant", int'(buffer_grants), 4);
    end
    drive(5'b00100, 5'b00100, 5'b00100, {3'd0, 3'd0, 3'd1, 3'd0, 3'd0});
    cycle();
    chk("tail_release_grant", int'(buffer_grants), 0);
    chk("tail_release_busy", int'(out_busy), 0);
    drive(5'b0, 5'b0, 5'b0, '0);
    cycle();

    do_reset();
    drive(5'b00010, 5'b0, 5'b0, {3'd0, 3'd6, 3'd0, 3'd0, 3'd0});
    for (int c = 0; c < 4; c++) begin
      cycle();
      chk("bad_flag", int'(bad_dest), 2);
      chk("bad_no_grant", int'(buffer_grants[1]), 0);
    end

    do_reset();
    for (int c = 0; c < 3000; c++) begin
      drive(5'($urandom), 5'($urandom), 5'($urandom),
            {3'($urandom_range(0, 5)), 3'($urandom_range(0, 5)), 3'($urandom_range(0, 5)),
             3'($urandom_range(0, 5)), 3'($urandom_range(0, 5))});
      cycle();
    end

    @(negedge clk);
    @(negedge clk);
    if (sbq.size() != 0) chk("sb_drain", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
